// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame-state encoding, framing constants
// and the odd-parity helpers used by the frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   FRAME_LEN = 11;
    // Start, parity and stop bits surround the payload.
    localparam int   DATA_BITS = FRAME_LEN - 3;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    function automatic logic frame_ok(input logic [7:0] data, input logic par,
                                      input logic stop);
        return (stop == STOP_BIT) && (par == odd_parity(data));
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-sample debouncer; outputs the
// filtered level and a one-cycle strobe on its 1->0 transition.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] samples;
    logic                  all_low;
    logic                  all_high;

    assign all_low  = ~|samples;
    assign all_high = &samples;

    // The strobe is asserted in the cycle the window turns all-low while the
    // registered level is still high, so it lasts exactly one cycle.
    assign fall = level & all_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= 2'b11;
            samples <= '1;
            level   <= 1'b1;
        end else begin
            sync    <= {sync[0], pin};
            samples <= {samples[FILTER_LEN-2:0], sync[1]};
            if (all_low) begin
                level <= 1'b0;
            end else if (all_high) begin
                level <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: filters the clock line, deserialises
// 11-bit frames, checks parity/stop and aborts stalled frames on timeout.
// Optional error counter output is enabled by defining PS2RX_ERR_COUNT_EN.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_US = 200,
    parameter int FILTER_LEN = 8
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic [7:0] ScanCode,
    output logic       NewCode,
    output logic       FrameErr,
    output logic       Busy
`ifdef PS2RX_ERR_COUNT_EN
    ,
    output logic [7:0] ErrCount
`endif
);

    localparam int TIMEOUT_CYCLES = (CLK_HZ / 1_000_000) * TIMEOUT_US;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] DATA   = ST_DATA;
    localparam logic [1:0] PARITY = ST_PARITY;
    localparam logic [1:0] STOP   = ST_STOP;

    logic            clk_level;
    logic            clk_fall;
    logic            edge_event;
    logic [1:0]      data_sync;
    logic            data_bit;
    logic [1:0]      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            parity_bit;
    logic [TO_W-1:0] timer;
    logic            timed_out;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (sys_clk),
        .rst  (rst),
        .pin  (PS2Clk),
        .level(clk_level),
        .fall (clk_fall)
    );

    // A fall is only meaningful while the filtered level is still high.
    assign edge_event = clk_fall & clk_level;
    assign data_bit   = data_sync[1];
    assign Busy       = (state != IDLE);
    assign timed_out  = (state != IDLE) && !edge_event && (timer == TO_LAST);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            data_sync <= 2'b11;
        end else begin
            data_sync <= {data_sync[0], PS2Data};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            timer      <= '0;
            ScanCode   <= 8'h00;
            NewCode    <= 1'b0;
            FrameErr   <= 1'b0;
        end else begin
            NewCode  <= 1'b0;
            FrameErr <= 1'b0;

            if (state == IDLE || edge_event) begin
                timer <= '0;
            end else begin
                timer <= timer + TO_W'(1);
            end

            if (timed_out) begin
                // Stalled frame: drop the partial byte and report it.
                state    <= IDLE;
                shift    <= '0;
                bit_cnt  <= '0;
                FrameErr <= 1'b1;
            end else if (edge_event) begin
                case (state)
                    IDLE: begin
                        if (data_bit == START_BIT) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= data_bit;
                        state      <= STOP;
                    end
                    STOP: begin
                        if (frame_ok(shift, parity_bit, data_bit)) begin
                            ScanCode <= shift;
                            NewCode  <= 1'b1;
                        end else begin
                            FrameErr <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PS2RX_ERR_COUNT_EN
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ErrCount <= 8'h00;
        end else if (FrameErr && ErrCount != 8'hFF) begin
            ErrCount <= ErrCount + 8'h01;
        end
    end
`endif

endmodule
